// File: rtl/io_ports.sv
// Multi-channel I/O port for the tiny16 bus: output latches, synchronised input with change detect, status/irq.
// Define IO_PORTS_DEBOUNCE_EN to compile in the input debounce counter.
module io_ports #(
    parameter int DATA_WIDTH      = 16,
    parameter int OUT_CHANNELS    = 2,
    parameter int OUT_WIDTH       = 8,
    parameter int IN_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_en,
    input  logic                              out_en,
    input  logic [3:0]                        sel,
    input  logic [DATA_WIDTH-1:0]             in,
    output logic [DATA_WIDTH-1:0]             out,
    input  logic [IN_WIDTH-1:0]               pins_in,
    output logic [OUT_CHANNELS*OUT_WIDTH-1:0] pins_out,
    output logic                              irq
);

    localparam logic [3:0] SEL_INPUT  = 4'd14;
    localparam logic [3:0] SEL_STATUS = 4'd15;

    if (DATA_WIDTH < 9 || DATA_WIDTH < OUT_WIDTH || DATA_WIDTH < IN_WIDTH ||
        OUT_CHANNELS < 1 || OUT_CHANNELS > 14 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("io_ports: illegal parameter combination");
    end

    logic [IN_WIDTH-1:0] sync_meta;
    logic [IN_WIDTH-1:0] sync;
    logic [IN_WIDTH-1:0] acc;
    logic [IN_WIDTH-1:0] acc_prev;
    logic                pending;
    logic                lost;
    logic                mask;
    logic                status_wr;
    logic                clr_pend;
    logic                clr_lost;
    logic                acc_change;
    logic                unused_in;

    assign unused_in = ^in;

    // Each channel owns its latch; pins_out doubles as the read-back source.
    for (genvar k = 0; k < OUT_CHANNELS; k++) begin : g_chan
        logic [OUT_WIDTH-1:0] latch_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                latch_q <= '0;
            end else if (in_en && sel == 4'(k)) begin
                latch_q <= in[OUT_WIDTH-1:0];
            end
        end

        assign pins_out[k*OUT_WIDTH +: OUT_WIDTH] = latch_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= pins_in;
            sync      <= sync_meta;
        end
    end

`ifdef IO_PORTS_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0]    db_count;
    logic [IN_WIDTH-1:0] acc_q;

    // sync_meta != sync means sync takes a new value at this edge, restarting the stability window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_count <= '0;
            acc_q    <= '0;
        end else if (sync == acc_q || sync_meta != sync) begin
            db_count <= '0;
        end else if (db_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            acc_q    <= sync;
            db_count <= '0;
        end else begin
            db_count <= db_count + CNT_W'(1);
        end
    end

    assign acc = acc_q;
`else
    assign acc = sync;
`endif

    assign status_wr  = in_en && (sel == SEL_STATUS);
    assign clr_pend   = status_wr && in[0];
    assign clr_lost   = status_wr && in[1];
    assign acc_change = (acc != acc_prev);

    // A change always wins over a clear; a change that collides with a pending clear leaves lost alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_prev <= '0;
            pending  <= 1'b0;
            lost     <= 1'b0;
            mask     <= 1'b0;
        end else begin
            acc_prev <= acc;
            if (acc_change) begin
                pending <= 1'b1;
            end else if (clr_pend) begin
                pending <= 1'b0;
            end
            if (acc_change && !clr_pend && pending) begin
                lost <= 1'b1;
            end else if (clr_lost && !(acc_change && clr_pend)) begin
                lost <= 1'b0;
            end
            if (status_wr) begin
                mask <= in[8];
            end
        end
    end

    assign irq = pending & mask;

    always_comb begin
        out = '0;
        if (out_en) begin
            if (sel == SEL_INPUT) begin
                out[IN_WIDTH-1:0] = acc;
            end else if (sel == SEL_STATUS) begin
                out[0] = pending;
                out[1] = lost;
                out[8] = mask;
            end else begin
                for (int k = 0; k < OUT_CHANNELS; k++) begin
                    if (sel == 4'(k)) begin
                        out[OUT_WIDTH-1:0] = pins_out[k*OUT_WIDTH +: OUT_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: directed steps plus randomized traffic against a behavioural model.
// Debounce steps run when IO_PORTS_DEBOUNCE_EN is defined (DEBOUNCE_CYCLES = 8).
module tb_io_ports;

    localparam int DW  = 16;
    localparam int OC  = 2;
    localparam int OW  = 8;
    localparam int IW  = 8;
    localparam int DBC = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_en;
    logic             out_en;
    logic [3:0]       sel;
    logic [DW-1:0]    bus_in;
    logic [DW-1:0]    bus_out;
    logic [IW-1:0]    pins_in;
    logic [OC*OW-1:0] pins_out;
    logic             irq;

    int errors = 0;
    int checks = 0;

    // Model state: latches, status bits, and the pin values sampled at the last three edges.
    logic [OW-1:0] m_lat [OC];
    logic          m_pend;
    logic          m_lost;
    logic          m_mask;
    logic [IW-1:0] pq [$];

    io_ports #(
        .DATA_WIDTH(DW), .OUT_CHANNELS(OC), .OUT_WIDTH(OW),
        .IN_WIDTH(IW), .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .out_en(out_en), .sel(sel),
        .in(bus_in), .out(bus_out), .pins_in(pins_in), .pins_out(pins_out), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] modelRead(input logic [3:0] s);
        logic [DW-1:0] r;
        r = '0;
        if (int'(s) < OC) r[OW-1:0] = m_lat[int'(s)];
        else if (s == 4'd14) r[IW-1:0] = pq[1];
        else if (s == 4'd15) begin
            r[0] = m_pend;
            r[1] = m_lost;
            r[8] = m_mask;
        end
        return r;
    endfunction

    function automatic logic [OC*OW-1:0] modelPins();
        logic [OC*OW-1:0] p;
        for (int k = 0; k < OC; k++) p[k*OW +: OW] = m_lat[k];
        return p;
    endfunction

    // acc shows the pins sampled two edges back; a difference between the two older samples is a change event now.
    task automatic modelEdge();
        logic change, clr_p, clr_l;
        if (!rst) begin
            for (int k = 0; k < OC; k++) m_lat[k] = '0;
            m_pend = 1'b0;
            m_lost = 1'b0;
            m_mask = 1'b0;
            pq = '{8'h00, 8'h00, 8'h00};
        end else begin
            change = (pq[1] != pq[0]);
            clr_p  = in_en && sel == 4'd15 && bus_in[0];
            clr_l  = in_en && sel == 4'd15 && bus_in[1];
            if (in_en && int'(sel) < OC) m_lat[int'(sel)] = bus_in[OW-1:0];
            if (change && clr_p) begin
                m_pend = 1'b1;
            end else if (change) begin
                if (m_pend) m_lost = 1'b1;
                else if (clr_l) m_lost = 1'b0;
                m_pend = 1'b1;
            end else begin
                if (clr_p) m_pend = 1'b0;
                if (clr_l) m_lost = 1'b0;
            end
            if (in_en && sel == 4'd15) m_mask = bus_in[8];
            pq.push_back(pins_in);
            void'(pq.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ie, input logic oe,
                                 input logic [3:0] s, input logic [DW-1:0] d);
        rst    = r;
        in_en  = ie;
        out_en = oe;
        sel    = s;
        bus_in = d;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic readCheck(input string tag, input logic [3:0] s, input logic [DW-1:0] exp);
        in_en  = 1'b0;
        out_en = 1'b1;
        sel    = s;
        #1;
        checkOutput(tag, bus_out, exp);
        out_en = 1'b0;
    endtask

    task automatic writeReg(input logic [3:0] s, input logic [DW-1:0] d);
        applyStimulus(1'b1, 1'b1, 1'b0, s, d);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, '0);
    endtask

    initial begin
        pq = '{8'h00, 8'h00, 8'h00};
        pins_in = '0;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 16'h00FF);
        @(negedge clk);
        ticks(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        #1;
        checkOutput("rst_pins_out", pins_out, 16'h0000);
        checkOutput("rst_irq", DW'(irq), 16'h0000);
        checkOutput("rst_out_idle", bus_out, 16'h0000);
        readCheck("rst_status", 4'd15, 16'h0000);
        readCheck("rst_input", 4'd14, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        writeReg(4'd0, 16'h00A5);
        writeReg(4'd1, 16'h003C);
        checkOutput("pins_out_3ca5", pins_out, 16'h3CA5);
        readCheck("rd_ch0", 4'd0, 16'h00A5);
        readCheck("rd_ch1", 4'd1, 16'h003C);
        readCheck("rd_unmapped", 4'd5, 16'h0000);
        writeReg(4'd5, 16'hFFFF);
        writeReg(4'd14, 16'hFFFF);
        checkOutput("wr_unmapped_pins", pins_out, 16'h3CA5);
        readCheck("rd_unmapped_after", 4'd5, 16'h0000);
        readCheck("rd_input_after_wr", 4'd14, 16'h0000);

        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 16'h0011);
        #1;
        checkOutput("rd_pre_write", bus_out, 16'h00A5);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        readCheck("rd_post_write", 4'd0, 16'h0011);
        checkOutput("pins_out_model", pins_out, modelPins());

`ifndef IO_PORTS_DEBOUNCE_EN
        writeReg(4'd15, 16'h0100);
        pins_in = 8'h81;
        tick();
        readCheck("acc_edge1", 4'd14, 16'h0000);
        tick();
        readCheck("acc_edge2", 4'd14, 16'h0081);
        checkOutput("irq_edge2", DW'(irq), 16'h0000);
        tick();
        checkOutput("irq_edge3", DW'(irq), 16'h0001);
        readCheck("status_pending", 4'd15, 16'h0101);

        pins_in = 8'h42;
        ticks(3);
        readCheck("status_lost", 4'd15, 16'h0103);
        writeReg(4'd15, 16'h0103);
        readCheck("status_cleared", 4'd15, 16'h0100);
        checkOutput("irq_cleared", DW'(irq), 16'h0000);

        pins_in = 8'h43;
        ticks(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd15, 16'h0101);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        readCheck("collide_status", 4'd15, 16'h0101);
        checkOutput("collide_irq", DW'(irq), 16'h0001);

        for (int i = 0; i < 300; i++) begin
            logic       r, ie, oe;
            logic [3:0] s;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 39) != 0);
            ie = 1'($urandom_range(0, 1));
            oe = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            d  = DW'($urandom);
            if ($urandom_range(0, 3) == 0) pins_in = IW'($urandom);
            applyStimulus(r, ie, oe, s, d);
            #1;
            checkOutput("rnd_out", bus_out, oe ? modelRead(s) : '0);
            checkOutput("rnd_pins_out", pins_out, modelPins());
            checkOutput("rnd_irq", DW'(irq), DW'(m_pend & m_mask));
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
`else
        writeReg(4'd15, 16'h0100);
        pins_in = 8'h01;
        ticks(5);
        pins_in = 8'h00;
        ticks(15);
        readCheck("glitch_acc", 4'd14, 16'h0000);
        readCheck("glitch_status", 4'd15, 16'h0100);

        pins_in = 8'h01;
        ticks(9);
        readCheck("db_acc_edge9", 4'd14, 16'h0000);
        tick();
        readCheck("db_acc_edge10", 4'd14, 16'h0001);
        checkOutput("db_irq_edge10", DW'(irq), 16'h0000);
        tick();
        checkOutput("db_irq_edge11", DW'(irq), 16'h0001);
        readCheck("db_status", 4'd15, 16'h0101);

        pins_in = 8'h00;
        ticks(6);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
        tick();
        checkOutput("midrst_pins_out", pins_out, 16'h0000);
        checkOutput("midrst_irq", DW'(irq), 16'h0000);
        readCheck("midrst_status", 4'd15, 16'h0000);
        readCheck("midrst_input", 4'd14, 16'h0000);
        pins_in = 8'h01;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
        ticks(9);
        readCheck("midrst_acc_edge9", 4'd14, 16'h0000);
        tick();
        readCheck("midrst_acc_edge10", 4'd14, 16'h0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
